// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debouncing.
//
// Drives one keypad column low at a time and samples the rows through a 2-FF
// synchronizer. A press is accepted after DEBOUNCE_SCANS consecutive matching
// samples, and a release after the same number of consecutive high samples.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset (synchronous release expected)
//   rows[3:0]  keypad rows, active-low, pulled up externally
//   cols[3:0]  keypad column drive, active-low, exactly one bit low
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high while the accepted key is considered pressed
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 4,  // clk cycles per column dwell, >= 4
    parameter int unsigned DEBOUNCE_SCANS = 3   // matching samples to accept, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    // One extra bit of headroom so the counter can hold DEBOUNCE_SCANS itself.
    localparam int unsigned MW = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    // Shared between press debouncing and release debouncing.
    logic [MW-1:0] match;

    logic          tick;
    logic          any_low;
    logic [1:0]    low_row;
    logic [1:0]    col_next;
    logic [MW-1:0] match_inc;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    always_comb begin
        tick      = (dwell == DWELL_LAST);
        any_low   = ~&rows_s;
        col_next  = col_idx + 2'd1;
        match_inc = match + MW'(1);
        // Lowest-index low row wins when several rows are pressed.
        if (!rows_s[0]) begin
            low_row = 2'd0;
        end else if (!rows_s[1]) begin
            low_row = 2'd1;
        end else if (!rows_s[2]) begin
            low_row = 2'd2;
        end else begin
            low_row = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StScan;
            rows_m    <= 4'b1111;
            rows_s    <= 4'b1111;
            dwell     <= '0;
            col_idx   <= 2'd0;
            cols      <= 4'b1110;
            row_idx   <= 2'd0;
            match     <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            dwell     <= tick ? '0 : dwell + DW'(1);
            key_valid <= 1'b0;

            if (tick) begin
                unique case (state)
                    StScan: begin
                        if (!any_low) begin
                            col_idx <= col_next;
                            cols    <= col_drive(col_next);
                        end else begin
                            row_idx <= low_row;
                            if (DEBOUNCE_SCANS == 1) begin
                                state     <= StHeld;
                                key_code  <= {low_row, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match     <= '0;
                            end else begin
                                state <= StDebounce;
                                match <= MW'(1);
                            end
                        end
                    end

                    StDebounce: begin
                        if (any_low && (low_row == row_idx)) begin
                            if (match_inc == MATCH_LAST) begin
                                state     <= StHeld;
                                key_code  <= {row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match     <= '0;
                            end else begin
                                match <= match_inc;
                            end
                        end else begin
                            // Bounce or a different row won: abandon this column.
                            state   <= StScan;
                            match   <= '0;
                            col_idx <= col_next;
                            cols    <= col_drive(col_next);
                        end
                    end

                    StHeld: begin
                        // Only the captured row matters; other rows are ignored.
                        if (rows_s[row_idx]) begin
                            if (match_inc == MATCH_LAST) begin
                                state    <= StScan;
                                key_held <= 1'b0;
                                match    <= '0;
                                col_idx  <= col_next;
                                cols     <= col_drive(col_next);
                            end else begin
                                match <= match_inc;
                            end
                        end else begin
                            match <= '0;
                        end
                    end

                    default: begin
                        state <= StScan;
                        match <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner. A behavioural keypad
// model turns a pressed-key mask into active-low rows from the driven columns.
// dut_a uses the default parameters, dut_b uses DEBOUNCE_SCANS=1.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows_a, cols_a, code_a;
    logic [3:0]  rows_b, cols_b, code_b;
    logic        valid_a, held_a, valid_b, held_b;
    logic [15:0] keys_a = 16'h0;   // bit r*4+c = key at row r, column c
    logic [15:0] keys_b = 16'h0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows_a),
        .cols      (cols_a),
        .key_code  (code_a),
        .key_valid (valid_a),
        .key_held  (held_a)
    );

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(1)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows      (rows_b),
        .cols      (cols_b),
        .key_code  (code_b),
        .key_valid (valid_b),
        .key_held  (held_b)
    );

    // Keypad matrix: a row reads low if any pressed key on it sits in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            rows_a[r] = ~|(keys_a[r*4 +: 4] & ~cols_a);
            rows_b[r] = ~|(keys_b[r*4 +: 4] & ~cols_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    // Waits (bounded) for a key_valid pulse on dut_a; returns on the negedge seeing it.
    task automatic wait_valid_a(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid_a) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_valid_a: key_valid=0 after %0d cycles, required=1", budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({cols_a, code_a, valid_a, held_a} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a: cols=%b code=%h valid=%b held=%b required 1110/0/0/0",
                     cols_a, code_a, valid_a, held_a);
        end
        vectors++;
        if ({cols_b, code_b, valid_b, held_b} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_b: cols=%b code=%h valid=%b held=%b required 1110/0/0/0",
                     cols_b, code_b, valid_b, held_b);
        end
    endtask

    // After release, column k/4 (mod 4) is driven following the k-th clock edge.
    task automatic test_idle_scan();
        logic [3:0] one;
        logic [3:0] exp;
        one = 4'b0001;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = ~(one << ((k / 4) % 4));
            vectors++;
            if (cols_a !== exp) begin
                miscompares++;
                $display("FAIL idle_cols k=%0d: cols=%b required=%b", k, cols_a, exp);
            end
            vectors++;
            if ({valid_a, held_a, code_a} !== 6'b0) begin
                miscompares++;
                $display("FAIL idle_outputs k=%0d: valid=%b held=%b code=%h required 0/0/0",
                         k, valid_a, held_a, code_a);
            end
        end
    endtask

    task automatic test_press_release();
        bit seen;
        int pulses;
        keys_a = 16'd1 << 9;   // row2, col1
        wait_valid_a(80, seen);
        if (seen) begin
            vectors++;
            if ({code_a, held_a} !== {4'h9, 1'b1}) begin
                miscompares++;
                $display("FAIL press_code: code=%h held=%b required 9/1", code_a, held_a);
            end
            // Stay aligned to the accepting tick: 40 cycles is a whole number of dwells.
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (valid_a) pulses++;
            end
            vectors++;
            if (pulses !== 0) begin
                miscompares++;
                $display("FAIL press_single_pulse: extra pulses=%0d required=0", pulses);
            end
            vectors++;
            if ({cols_a, held_a} !== {4'b1101, 1'b1}) begin
                miscompares++;
                $display("FAIL press_frozen: cols=%b held=%b required 1101/1", cols_a, held_a);
            end
            keys_a = 16'h0;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                vectors++;
                if (i < 12) begin
                    if (held_a !== 1'b1) begin
                        miscompares++;
                        $display("FAIL release_hold i=%0d: held=%b required=1", i, held_a);
                    end
                end else begin
                    if ({held_a, cols_a, code_a} !== {1'b0, 4'b1011, 4'h9}) begin
                        miscompares++;
                        $display("FAIL release_done: held=%b cols=%b code=%h required 0/1011/9",
                                 held_a, cols_a, code_a);
                    end
                end
            end
        end
    endtask

    task automatic test_bounce();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cols_a == 4'b0111) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL bounce_find_col3: cols never 0111, required=0111");
        end else begin
            keys_a = 16'd1 << 3;   // row0, col3: seen on exactly one sample tick
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (i == 4) keys_a = 16'h0;
                vectors++;
                if ({valid_a, held_a} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL bounce_no_key i=%0d: valid=%b held=%b required 0/0",
                             i, valid_a, held_a);
                end
                if (i == 7) begin
                    vectors++;
                    if (cols_a !== 4'b0111) begin
                        miscompares++;
                        $display("FAIL bounce_frozen: cols=%b required=0111", cols_a);
                    end
                end
                if (i == 8) begin
                    vectors++;
                    if (cols_a !== 4'b1110) begin
                        miscompares++;
                        $display("FAIL bounce_resume: cols=%b required=1110", cols_a);
                    end
                end
            end
        end
    endtask

    task automatic test_multi_row();
        bit seen;
        bit released;
        int pulses;
        keys_a = (16'd1 << 4) | (16'd1 << 12);   // rows 1 and 3, col0
        wait_valid_a(80, seen);
        if (seen) begin
            vectors++;
            if ({code_a, held_a} !== {4'h4, 1'b1}) begin
                miscompares++;
                $display("FAIL multi_code: code=%h held=%b required 4/1", code_a, held_a);
            end
            keys_a = keys_a | (16'd1 << 8);   // add row2, col0 while held
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (valid_a) pulses++;
            end
            vectors++;
            if ({pulses, code_a, held_a} !== {32'd0, 4'h4, 1'b1}) begin
                miscompares++;
                $display("FAIL multi_no_repulse: pulses=%0d code=%h held=%b required 0/4/1",
                         pulses, code_a, held_a);
            end
        end
        keys_a = 16'h0;
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk);
            if (!held_a) released = 1'b1;
        end
        vectors++;
        if (!released || code_a !== 4'h4) begin
            miscompares++;
            $display("FAIL multi_release: held=%b code=%h required 0/4", held_a, code_a);
        end
    endtask

    task automatic test_reset_midway();
        bit seen;
        bit released;
        keys_a = 16'd1 << 15;   // row3, col3
        wait_valid_a(80, seen);
        vectors++;
        if (code_a !== 4'hF) begin
            miscompares++;
            $display("FAIL midreset_first_code: code=%h required=f", code_a);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (held_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_held: held=%b required=1", held_a);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cols_a, code_a, valid_a, held_a} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_clear: cols=%b code=%h valid=%b held=%b required 1110/0/0/0",
                     cols_a, code_a, valid_a, held_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid_a(80, seen);
        if (seen) begin
            vectors++;
            if ({code_a, held_a} !== {4'hF, 1'b1}) begin
                miscompares++;
                $display("FAIL midreset_rediscover: code=%h held=%b required f/1",
                         code_a, held_a);
            end
        end
        keys_a = 16'h0;
        released = 1'b0;
        for (int i = 0; i < 40 && !released; i++) begin
            @(negedge clk);
            if (!held_a) released = 1'b1;
        end
        vectors++;
        if (!released) begin
            miscompares++;
            $display("FAIL midreset_release: held=%b required=0", held_a);
        end
    endtask

    task automatic test_single_debounce();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cols_b == 4'b1011) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL single_find_col2: cols never 1011, required=1011");
        end else begin
            keys_b = 16'd1 << 14;   // row3, col2
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                vectors++;
                if (i < 4) begin
                    if (valid_b !== 1'b0) begin
                        miscompares++;
                        $display("FAIL single_early i=%0d: valid=%b required=0", i, valid_b);
                    end
                end else begin
                    if ({valid_b, code_b, held_b} !== {1'b1, 4'hE, 1'b1}) begin
                        miscompares++;
                        $display("FAIL single_accept: valid=%b code=%h held=%b required 1/e/1",
                                 valid_b, code_b, held_b);
                    end
                end
            end
            keys_b = 16'h0;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                if (i == 1) begin
                    vectors++;
                    if (valid_b !== 1'b0) begin
                        miscompares++;
                        $display("FAIL single_pulse_width: valid=%b required=0", valid_b);
                    end
                end
                vectors++;
                if (i < 4) begin
                    if (held_b !== 1'b1) begin
                        miscompares++;
                        $display("FAIL single_hold i=%0d: held=%b required=1", i, held_b);
                    end
                end else begin
                    if ({held_b, cols_b, code_b} !== {1'b0, 4'b0111, 4'hE}) begin
                        miscompares++;
                        $display("FAIL single_release: held=%b cols=%b code=%h required 0/0111/e",
                                 held_b, cols_b, code_b);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_multi_row();
        test_reset_midway();
        test_single_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
